// File: rtl/dmem_responder.sv
// Purpose : single-port data memory responder for a CPU-side initiator.
//           An accepted request goes IDLE -> WAIT (WAIT cycles) -> RESP,
//           where a one-cycle ready pulse completes it.
// Latency : ready is high in the cycle after edge (accept + WAIT); a new
//           request is accepted at the earliest WAIT+2 cycles after the last.
// Backpr. : none. req is only looked at in IDLE. busy flags that the block
//           is not idle. There is no queueing.
// Ports   : clk, rst (async, active-high); req/we/addr/wdata/be request side;
//           ready/rdata/busy response side; err only with DMEM_RANGE_CHK_EN.
// Config  : DMEM_RANGE_CHK_EN adds the err port. Any access with
//           addr[31:2] >= DEPTH then completes with err=1 and rdata=0, and
//           its write is dropped. Without the macro the address wraps.
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy
`ifdef DMEM_RANGE_CHK_EN
    ,
    output logic        err
`endif
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic            accept;

    // Request fields captured at the accepting edge.
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            oor_q;
    logic            oor_in;

    logic [31:0]     mem [DEPTH];

`ifdef DMEM_RANGE_CHK_EN
    assign oor_in = (addr[31:2] >= 30'(DEPTH));
`else
    assign oor_in = 1'b0;
`endif

    // addr[1:0] never selects anything, and the upper bits are only used by
    // the range check.
    logic unused_addr;
    assign unused_addr = ^{addr[1:0], addr[31:AW+2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            oor_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= we;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
            be_q    <= be;
            oor_q   <= oor_in;
        end
    end

    // The write commits at the edge that closes RESP. An async reset drops
    // state out of RESP right away, so a reset raised in RESP aborts it.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RESP && we_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state == S_RESP);
    assign busy  = (state != S_IDLE);
    // No write can land before RESP ends, so this read gives the word as it
    // was on entry to RESP.
    assign rdata = (ready && !we_q && !oor_q) ? mem[idx_q] : 32'd0;

`ifdef DMEM_RANGE_CHK_EN
    assign err = ready && oor_q;
`endif

endmodule
